evm_id_database: RTL and testbench
==================================

EVM_ID_DATABASE -- requirements
Module: evm_id_database

Interface
REQ-001 Parameter ID_W, default 5: width of all ID fields.
REQ-002 Parameter DEPTH, default 16: number of voter table entries.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): table address width.
REQ-004 Parameter OFFICER_ID, default all ones: ID that opens an officer session.
REQ-005 Parameter RESET_ID, default 'h15: ID that clears voted flags.
REQ-006 Parameter MAX_FAIL, default 3: failed officer attempts before lockout.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  the single clock; all logic on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 mode  in  1  0 = enroll, 1 = vote; sampled only with voter_req.
REQ-011 officer_id  in  ID_W, plus officer_req  in  1  (one-cycle strobe).
REQ-012 voter_id  in  ID_W, plus voter_req  in  1  (one-cycle strobe).
REQ-013 reset_id  in  ID_W, plus reset_req  in  1  (one-cycle strobe).
REQ-014 vote_done  in  1  ballot cast acknowledgement from the vote counter.
REQ-015 officer_id_status  out  1  level; officer session open.
REQ-016 result_valid  out  1  one-cycle pulse; voter_id_status is valid.
REQ-017 voter_id_status  out  1  1 = accepted, 0 = rejected; qualified by result_valid.
REQ-018 reset_id_status  out  1  one-cycle pulse; voted flags cleared.
REQ-019 valid_voter  out  ID_W, plus valid_voter_address  out  ADDR_W  granted ID and its table slot; zero outside GRANT.
REQ-020 write  out  1  one-cycle pulse on every table update (enroll or vote mark).
REQ-021 busy  out  1  high in LOOKUP and GRANT.
REQ-022 lockout  out  1  high in LOCKOUT.
REQ-023 enrolled_count  out  ADDR_W+1; voted_count  out  ADDR_W+1.

Function
REQ-024 The FSM SHALL have states IDLE, AUTH, LOOKUP, GRANT and LOCKOUT.
REQ-025 IDLE: officer_req with officer_id==OFFICER_ID -> AUTH and clear the fail count; officer_id_status rises the next cycle.
REQ-026 IDLE: officer_req with a mismatched ID increments the fail count; reaching MAX_FAIL -> LOCKOUT, which only reset exits.
REQ-027 AUTH: voter_req -> LOOKUP, latching voter_id and mode; busy rises the next cycle.
REQ-028 LOOKUP: compare one table entry per cycle, indexes 0..enrolled_count-1; a hit at index k gives result_valid k+2 cycles after the voter_req edge.
REQ-029 A miss gives result_valid enrolled_count+2 cycles after req; with an empty table, result_valid comes 2 cycles after req.
REQ-030 Vote mode, hit on an unvoted entry: voter_id_status=1 and enter GRANT.
REQ-031 Vote mode, hit on an already-voted entry, or a miss: voter_id_status=0 and return to AUTH.
REQ-032 Enroll mode, miss with enrolled_count<DEPTH: write the ID at slot enrolled_count with a write pulse, increment the count, voter_id_status=1, return to AUTH.
REQ-033 Enroll mode, hit (duplicate) or full table: voter_id_status=0 and no write.
REQ-034 GRANT: hold valid_voter and valid_voter_address; vote_done sets the voted flag, pulses write, increments voted_count, returns to AUTH.
REQ-035 AUTH only: reset_req with reset_id==RESET_ID clears all voted flags and voted_count and pulses reset_id_status; enrollment is retained.
REQ-036 A mismatched reset_id produces no action and no pulse.
REQ-037 reset_req and voter_req in the same AUTH cycle: the reset wins and voter_req is dropped.
REQ-038 In LOOKUP and GRANT, voter_req, officer_req and reset_req SHALL be ignored; mode changes have no effect.
REQ-039 vote_done outside GRANT SHALL be ignored.

Reset
REQ-040 On reset: state=IDLE; every output 0; counts, fail counter, all table valid and voted flags cleared.
REQ-041 A reset during LOOKUP or GRANT aborts the operation with no write pulse.

Structure
REQ-042 Package evm_id_pkg SHALL hold the state enum and the mode encodings (MODE_ENROLL=0, MODE_VOTE=1).
REQ-043 Sub-module evm_id_table SHALL hold the ID array and voted-flag vector: one indexed read port, one write port, a bulk voted-clear input.

Verification
REQ-044 Officer 11111 accepted, then enroll 00000, 00010 -> two write pulses, enrolled_count=2.
REQ-045 Vote 00010 -> result_valid at req+3 with status 1, GRANT at address 1; vote_done -> write, voted_count=1.
REQ-046 Repeat vote 00010 -> status 0; vote 11000 (miss) -> status 0 at req+4.
REQ-047 Three officer IDs 00001 -> lockout=1; a correct ID is then ignored until reset.
REQ-048 reset_req 10101 together with voter_req -> reset_id_status pulse, voted_count=0, no lookup; re-vote 00010 is accepted.
REQ-049 Enroll DEPTH IDs, then one more -> rejected with no write; reset asserted in GRANT -> all outputs 0 and no write.

Source files
------------

// File: rtl/evm_id_pkg.sv
// evm_id_pkg: shared state encoding and voter-request mode values for the EVM ID database.
package evm_id_pkg;
  typedef enum logic [2:0] {IDLE, AUTH, LOOKUP, GRANT, LOCKOUT} state_t;
  localparam logic MODE_ENROLL = 1'b0;
  localparam logic MODE_VOTE = 1'b1;
endpackage

// File: rtl/evm_id_table.sv
// evm_id_table: voter ID array plus voted flags; one async read port, one write port, bulk voted clear.
module evm_id_table import evm_id_pkg::*; #(
  parameter int ID_W = 5,
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ID_W-1:0]   rd_id,
  output logic              rd_voted,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ID_W-1:0]   wr_id,
  input  logic              wr_voted,
  input  logic              clr_voted
);
  logic [ID_W-1:0] ids [DEPTH];
  logic [DEPTH-1:0] voted;
  assign rd_id = ids[rd_addr];
  assign rd_voted = voted[rd_addr];
  // IDs need no reset: slots at or above the enrolled count are never matched
  always_ff @(posedge clk) if (wr_en) ids[wr_addr] <= wr_id;
  always_ff @(posedge clk) begin
    if (reset || clr_voted) voted <= '0;
    else if (wr_en) voted[wr_addr] <= wr_voted;
  end
endmodule

// File: rtl/evm_id_database.sv
// evm_id_database: officer-gated voter enrollment and vote authorization with a sequential table scan.
module evm_id_database import evm_id_pkg::*; #(
  parameter int ID_W = 5,
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter logic [ID_W-1:0] OFFICER_ID = '1,
  parameter logic [ID_W-1:0] RESET_ID = 'h15,
  parameter int MAX_FAIL = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [ID_W-1:0]   officer_id,
  input  logic              officer_req,
  input  logic [ID_W-1:0]   voter_id,
  input  logic              voter_req,
  input  logic [ID_W-1:0]   reset_id,
  input  logic              reset_req,
  input  logic              vote_done,
  output logic              officer_id_status,
  output logic              result_valid,
  output logic              voter_id_status,
  output logic              reset_id_status,
  output logic [ID_W-1:0]   valid_voter,
  output logic [ADDR_W-1:0] valid_voter_address,
  output logic              write,
  output logic              busy,
  output logic              lockout,
  output logic [ADDR_W:0]   enrolled_count,
  output logic [ADDR_W:0]   voted_count
);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  state_t state, state_n;
  logic [ID_W-1:0] id_q, rd_id;
  logic mode_q, primed, rd_voted, wr_en, wr_voted, clr_voted;
  logic [ADDR_W:0] idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [FW-1:0] fail_cnt;
  logic officer_ok, reset_ok, hit, miss, done, grant, enroll_ok;
  assign officer_ok = officer_req && officer_id == OFFICER_ID;
  assign reset_ok = reset_req && reset_id == RESET_ID;
  // first LOOKUP cycle only arms the scan, so slot j is judged j+1 cycles after entry
  assign hit = state == LOOKUP && primed && idx < enrolled_count && rd_id == id_q;
  assign miss = state == LOOKUP && primed && idx == enrolled_count;
  assign done = hit || miss;
  assign grant = mode_q == MODE_VOTE && hit && !rd_voted;
  assign enroll_ok = mode_q == MODE_ENROLL && miss && enrolled_count < FULL;
  assign officer_id_status = state == AUTH || state == LOOKUP || state == GRANT;
  assign busy = state == LOOKUP || state == GRANT;
  assign lockout = state == LOCKOUT;
  assign valid_voter = state == GRANT ? id_q : '0;
  assign valid_voter_address = state == GRANT ? idx[ADDR_W-1:0] : '0;
  assign wr_addr = state == GRANT ? idx[ADDR_W-1:0] : enrolled_count[ADDR_W-1:0];
  evm_id_table #(.ID_W(ID_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_table (
    .clk(clk), .reset(reset), .rd_addr(idx[ADDR_W-1:0]), .rd_id(rd_id), .rd_voted(rd_voted),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_id(id_q), .wr_voted(wr_voted), .clr_voted(clr_voted)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    wr_en = 1'b0;
    wr_voted = 1'b0;
    clr_voted = 1'b0;
    case (state)
      IDLE: state_n = officer_ok ? AUTH : (officer_req && fail_cnt == FW'(MAX_FAIL - 1)) ? LOCKOUT : IDLE;
      AUTH: begin
        clr_voted = reset_ok;
        state_n = !reset_ok && voter_req ? LOOKUP : AUTH;
      end
      LOOKUP: begin
        wr_en = enroll_ok;
        state_n = grant ? GRANT : done ? AUTH : LOOKUP;
      end
      GRANT: begin
        wr_en = vote_done;
        wr_voted = vote_done;
        state_n = vote_done ? AUTH : GRANT;
      end
      default: state_n = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q <= '0;
      mode_q <= 1'b0;
      idx <= '0;
      primed <= 1'b0;
      fail_cnt <= '0;
      result_valid <= 1'b0;
      voter_id_status <= 1'b0;
      reset_id_status <= 1'b0;
      write <= 1'b0;
      enrolled_count <= '0;
      voted_count <= '0;
    end else begin
      result_valid <= done;
      voter_id_status <= grant || enroll_ok;
      reset_id_status <= clr_voted;
      write <= wr_en;
      if (state == IDLE && officer_req) fail_cnt <= officer_ok ? '0 : fail_cnt + 1'b1;
      if (state == AUTH && voter_req && !reset_ok) begin
        id_q <= voter_id;
        mode_q <= mode;
        idx <= '0;
        primed <= 1'b0;
      end
      if (state == LOOKUP && !done) begin
        primed <= 1'b1;
        if (primed) idx <= idx + 1'b1;
      end
      if (wr_en && !wr_voted) enrolled_count <= enrolled_count + 1'b1;
      if (clr_voted) voted_count <= '0;
      else if (wr_en && wr_voted) voted_count <= voted_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_evm_id_database.sv
// tb_evm_id_database: scoreboard bench for enrollment, voting, officer lockout and voted-flag reset.
module tb_evm_id_database;
  import evm_id_pkg::*;
  typedef struct {logic st; int cyc;} exp_t;
  logic clk = 1'b0, reset = 1'b0, mode = 1'b0, officer_req = 1'b0, voter_req = 1'b0;
  logic reset_req = 1'b0, vote_done = 1'b0;
  logic [4:0] officer_id = '0, voter_id = '0, reset_id = '0;
  logic officer_id_status, result_valid, voter_id_status, reset_id_status, write, busy, lockout;
  logic [4:0] valid_voter, enrolled_count, voted_count;
  logic [3:0] valid_voter_address;
  int n_tests = 0, n_fail = 0, cyc = 0, wr_cnt = 0, rv_cnt = 0, rid_cnt = 0, w0, r0;
  exp_t sb[$];
  evm_id_database dut (
    .clk(clk), .reset(reset), .mode(mode), .officer_id(officer_id), .officer_req(officer_req),
    .voter_id(voter_id), .voter_req(voter_req), .reset_id(reset_id), .reset_req(reset_req),
    .vote_done(vote_done), .officer_id_status(officer_id_status), .result_valid(result_valid),
    .voter_id_status(voter_id_status), .reset_id_status(reset_id_status), .valid_voter(valid_voter),
    .valid_voter_address(valid_voter_address), .write(write), .busy(busy), .lockout(lockout),
    .enrolled_count(enrolled_count), .voted_count(voted_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (write) wr_cnt++;
    if (reset_id_status) rid_cnt++;
    if (result_valid) begin
      rv_cnt++;
      check("sb_extra", sb.size(), 1);
      if (sb.size() != 0) begin
        check("status", voter_id_status, sb[0].st);
        check("latency", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask
  task automatic officer(input logic [4:0] id);
    @(negedge clk);
    officer_id = id;
    officer_req = 1'b1;
    @(negedge clk);
    officer_req = 1'b0;
  endtask
  task automatic voter(input logic [4:0] id, input logic m, input logic st, input int lat);
    @(negedge clk);
    sb.push_back('{st: st, cyc: cyc + 1 + lat});
    voter_id = id;
    mode = m;
    voter_req = 1'b1;
    @(negedge clk);
    voter_req = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    sb.delete();
  endtask
  task automatic pulse_done();
    @(negedge clk);
    vote_done = 1'b1;
    @(negedge clk);
    vote_done = 1'b0;
  endtask
  initial begin
    do_reset();
    check("rst_off", officer_id_status, 0);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_lock", lockout, 0);
    check("rst_cnt", {enrolled_count, voted_count}, 0);
    check("rst_vv", {valid_voter, valid_voter_address, write}, 0);
    officer(5'b11111);
    check("off_open", officer_id_status, 1);
    voter(5'b00000, MODE_ENROLL, 1'b1, 2);
    voter(5'b00010, MODE_ENROLL, 1'b1, 3);
    check("enr_wr", wr_cnt, 2);
    check("enr_cnt", enrolled_count, 2);
    voter(5'b00010, MODE_VOTE, 1'b1, 3);
    check("grant_id", valid_voter, 5'b00010);
    check("grant_addr", valid_voter_address, 1);
    check("grant_busy", busy, 1);
    @(negedge clk);
    reset_id = 5'h15;
    reset_req = 1'b1;
    officer_req = 1'b1;
    officer_id = 5'b11111;
    voter_req = 1'b1;
    @(negedge clk);
    {reset_req, officer_req, voter_req} = '0;
    repeat (2) @(negedge clk);
    check("grant_ign_rid", rid_cnt, 0);
    check("grant_ign_rv", rv_cnt, 3);
    check("grant_hold", valid_voter, 5'b00010);
    pulse_done();
    check("vote_wr", wr_cnt, 3);
    check("vote_cnt", voted_count, 1);
    check("vote_idle", busy, 0);
    voter(5'b00010, MODE_VOTE, 1'b0, 3);
    voter(5'b11000, MODE_VOTE, 1'b0, 4);
    voter(5'b00000, MODE_ENROLL, 1'b0, 2);
    check("dup_wr", wr_cnt, 3);
    pulse_done();
    check("stray_done", wr_cnt, 3);
    @(negedge clk);
    reset_id = 5'b00111;
    reset_req = 1'b1;
    @(negedge clk);
    reset_req = 1'b0;
    @(negedge clk);
    check("bad_rid", rid_cnt, 0);
    check("bad_rid_cnt", voted_count, 1);
    r0 = rv_cnt;
    @(negedge clk);
    reset_id = 5'b10101;
    reset_req = 1'b1;
    voter_id = 5'b00010;
    mode = MODE_VOTE;
    voter_req = 1'b1;
    @(negedge clk);
    {reset_req, voter_req} = '0;
    repeat (5) @(negedge clk);
    check("rid_pulse", rid_cnt, 1);
    check("rid_cnt0", voted_count, 0);
    check("rid_nolook", rv_cnt, r0);
    check("rid_enr", enrolled_count, 2);
    voter(5'b00010, MODE_VOTE, 1'b1, 3);
    pulse_done();
    check("revote_cnt", voted_count, 1);
    do_reset();
    repeat (3) officer(5'b00001);
    check("lock", lockout, 1);
    officer(5'b11111);
    check("lock_hold", lockout, 1);
    check("lock_off", officer_id_status, 0);
    do_reset();
    check("lock_clr", lockout, 0);
    officer(5'b11111);
    for (int i = 0; i < 16; i++) voter(5'(i), MODE_ENROLL, 1'b1, i + 2);
    check("full_cnt", enrolled_count, 16);
    w0 = wr_cnt;
    voter(5'd16, MODE_ENROLL, 1'b0, 18);
    check("full_nowr", wr_cnt, w0);
    voter(5'd15, MODE_VOTE, 1'b1, 17);
    check("full_addr", valid_voter_address, 15);
    @(negedge clk);
    reset = 1'b1;
    vote_done = 1'b1;
    @(negedge clk);
    check("abort_wr", wr_cnt, w0);
    check("abort_out", {officer_id_status, result_valid, voter_id_status, reset_id_status, busy, lockout, write}, 0);
    check("abort_vv", {valid_voter, valid_voter_address}, 0);
    check("abort_cnt", {enrolled_count, voted_count}, 0);
    reset = 1'b0;
    vote_done = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_wr2", wr_cnt, w0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
